// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the memory-mapped interval timer: base address,
// register index enum and CTRL/STATUS bit positions.
package mmio_timer_pkg;

    localparam logic [15:0] TIMER_BASE = 16'hC008;

    typedef enum logic [1:0] {
        TMR_CTRL   = 2'd0,
        TMR_LOAD   = 2'd1,
        TMR_COUNT  = 2'd2,
        TMR_STATUS = 2'd3
    } timer_reg_t;

    localparam int TMR_EN_BIT    = 0;
    localparam int TMR_PER_BIT   = 1;
    localparam int TMR_PRESC_LSB = 16;
    localparam int TMR_EXP_BIT   = 0;

endpackage

// File: rtl/mmio_timer_if.sv
// Processor-side register bus between the memory-map decoder and the timer.
interface mmio_timer_if;
    logic        sel_i;
    logic [1:0]  addr_i;
    logic [3:0]  we_i;
    logic [3:0]  re_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;

    modport master (output sel_i, addr_i, we_i, re_i, wdata_i, input rdata_o);
    modport slave  (input sel_i, addr_i, we_i, re_i, wdata_i, output rdata_o);
endinterface

// File: rtl/mmio_timer_prescaler.sv
// Prescale counter: counts 0..presc_i while enabled and ticks on the last
// count; held at zero while disabled so a fresh enable always starts at 0.
module mmio_timer_prescaler #(
    parameter int PRESC_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  logic [PRESC_WIDTH-1:0] presc_i,
    output logic                   tick_o
);

    logic [PRESC_WIDTH-1:0] cnt_q, cnt_d;

    // >= rather than == so lowering PRESC mid-run cannot push the count into a wrap
    always_comb begin
        tick_o = en_i && (cnt_q >= presc_i);
        cnt_d  = cnt_q + PRESC_WIDTH'(1);
        if (!en_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting interval timer (CTRL/LOAD/COUNT/STATUS).
// Define MMIO_TIMER_IRQ_EN to build the registered one-cycle irq_o expiry pulse.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter int CNT_WIDTH   = 32,
    parameter int PRESC_WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    mmio_timer_if.slave  bus,
    output logic         expired_o
`ifdef MMIO_TIMER_IRQ_EN
    ,
    output logic         irq_o
`endif
);

    logic [31:0]          ctrl_q, ctrl_d;
    logic [CNT_WIDTH-1:0] load_q, load_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 expired_q, expired_d;

    timer_reg_t reg_idx;
    logic       wr, rd, tick, en, expiry, en_rise;

    assign reg_idx = timer_reg_t'(bus.addr_i);
    assign wr      = bus.sel_i && (|bus.we_i);
    assign rd      = bus.sel_i && (|bus.re_i);
    assign en      = ctrl_q[TMR_EN_BIT];
    assign expiry  = tick && en && (count_q == '0);
    assign en_rise = wr && (reg_idx == TMR_CTRL) && !en && bus.wdata_i[TMR_EN_BIT];

    mmio_timer_prescaler #(
        .PRESC_WIDTH (PRESC_WIDTH)
    ) u_presc (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (en),
        .presc_i (ctrl_q[TMR_PRESC_LSB +: PRESC_WIDTH]),
        .tick_o  (tick)
    );

    // Counter events are applied first so that bus writes override them.
    always_comb begin
        ctrl_d    = ctrl_q;
        load_d    = load_q;
        count_d   = count_q;
        expired_d = expired_q;

        if (tick && en) begin
            if (count_q != '0) begin
                count_d = count_q - CNT_WIDTH'(1);
            end else if (ctrl_q[TMR_PER_BIT]) begin
                count_d = load_q;
            end else begin
                ctrl_d[TMR_EN_BIT] = 1'b0;
            end
        end

        if (wr) begin
            unique case (reg_idx)
                TMR_CTRL: begin
                    ctrl_d = bus.wdata_i;
                    if (en_rise) begin
                        count_d = load_q;
                    end
                end
                TMR_LOAD:   load_d  = bus.wdata_i[CNT_WIDTH-1:0];
                TMR_COUNT:  count_d = bus.wdata_i[CNT_WIDTH-1:0];
                TMR_STATUS: begin
                    if (bus.wdata_i[TMR_EXP_BIT]) begin
                        expired_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (expiry) begin
            expired_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            load_q    <= '0;
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    always_comb begin
        bus.rdata_o = '0;
        if (rd) begin
            unique case (reg_idx)
                TMR_CTRL:   bus.rdata_o = ctrl_q;
                TMR_LOAD:   bus.rdata_o = 32'(load_q);
                TMR_COUNT:  bus.rdata_o = 32'(count_q);
                TMR_STATUS: bus.rdata_o = {30'b0, en, expired_q};
                default:    bus.rdata_o = '0;
            endcase
        end
    end

    assign expired_o = expired_q;

`ifdef MMIO_TIMER_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = expiry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: expected values are queued as stimulus is
// applied and popped when the corresponding register or output is sampled.
module tb_mmio_timer;
    import mmio_timer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic expired_o;
`ifdef MMIO_TIMER_IRQ_EN
    logic irq_o;
`endif

    mmio_timer_if bus_if ();

    mmio_timer #(.CNT_WIDTH(32), .PRESC_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .expired_o (expired_o)
`ifdef MMIO_TIMER_IRQ_EN
        ,
        .irq_o     (irq_o)
`endif
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got, e;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_if.sel_i   = 1'b1;
        bus_if.addr_i  = a;
        bus_if.we_i    = 4'hF;
        bus_if.wdata_i = d;
        @(posedge clk);
        #1;
        bus_if.sel_i   = 1'b0;
        bus_if.we_i    = 4'h0;
        bus_if.wdata_i = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus_if.sel_i  = 1'b1;
        bus_if.addr_i = a;
        bus_if.re_i   = 4'hF;
        #1;
        d = bus_if.rdata_o;
        bus_if.sel_i  = 1'b0;
        bus_if.re_i   = 4'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.sel_i = 1'b0; bus_if.addr_i = '0; bus_if.we_i = '0;
        bus_if.re_i = '0; bus_if.wdata_i = '0;
        #35;
        rst_n = 1'b1;
        step(1);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0);
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), got);
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset_reg%0d got=%h exp=%h", i, got, e);
            end
        end
        exp_q.push_back(32'h0);
        e = exp_q.pop_front();
        vectors++;
        if (32'(expired_o) !== e) begin
            miscompares++;
            $display("FAIL reset_expired got=%b exp=%h", expired_o, e);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] exp_irq;
        wr(TMR_LOAD, 32'd4);
        wr(TMR_CTRL, 32'h1);
        for (int i = 0; i <= 6; i++) begin
            exp_q.push_back(32'(i >= 5));
            e = exp_q.pop_front();
            vectors++;
            if (32'(expired_o) !== e) begin
                miscompares++;
                $display("FAIL oneshot_expired cyc+%0d got=%b exp=%h", i, expired_o, e);
            end
`ifdef MMIO_TIMER_IRQ_EN
            exp_irq = 32'(i == 5);
            vectors++;
            if (32'(irq_o) !== exp_irq) begin
                miscompares++;
                $display("FAIL oneshot_irq cyc+%0d got=%b exp=%h", i, irq_o, exp_irq);
            end
`else
            exp_irq = 32'h0;
`endif
            if (i < 6) step(1);
        end
        step(3);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        rd(TMR_CTRL, got);
        e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL oneshot_ctrl got=%h exp=%h", got, e); end
        rd(TMR_COUNT, got);
        e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL oneshot_count got=%h exp=%h", got, e); end
        rd(TMR_STATUS, got);
        e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL oneshot_status got=%h exp=%h", got, e); end
        wr(TMR_STATUS, 32'h1);
        exp_q.push_back(32'h0);
        rd(TMR_STATUS, got);
        e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL oneshot_clear got=%h exp=%h", got, e); end
    endtask

    task automatic test_periodic();
        int  t0;
        bit  found;
        wr(TMR_LOAD, 32'd2);
        wr(TMR_CTRL, 32'h0003_0003);
        t0 = cyc;
        for (int p = 0; p < 3; p++) begin
            found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                step(1);
                if (expired_o) found = 1'b1;
            end
            exp_q.push_back(32'd12);
            e = exp_q.pop_front(); vectors++;
            if (!found || 32'(cyc - t0) !== e) begin
                miscompares++;
                $display("FAIL periodic_period%0d got=%0d exp=%0d found=%0b", p, cyc - t0, e, found);
            end
            t0 = cyc;
            exp_q.push_back(32'd2);
            rd(TMR_COUNT, got);
            e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL periodic_reload%0d got=%h exp=%h", p, got, e); end
            wr(TMR_STATUS, 32'h1);
        end
        wr(TMR_CTRL, 32'h0);
        wr(TMR_STATUS, 32'h1);
    endtask

    task automatic test_w1c_race();
        wr(TMR_LOAD, 32'd2);
        wr(TMR_CTRL, 32'h3);
        step(2);
        wr(TMR_STATUS, 32'h1);
        exp_q.push_back(32'h3);
        rd(TMR_STATUS, got);
        e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL w1c_race got=%h exp=%h", got, e); end
        wr(TMR_STATUS, 32'h1);
        exp_q.push_back(32'h2);
        rd(TMR_STATUS, got);
        e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL w1c_later got=%h exp=%h", got, e); end
        wr(TMR_CTRL, 32'h0);
        wr(TMR_STATUS, 32'h1);
    endtask

    task automatic test_count_write_tick();
        logic [31:0] seq [4];
        seq[0] = 32'h7; seq[1] = 32'h10; seq[2] = 32'h10; seq[3] = 32'hF;
        wr(TMR_LOAD, 32'd7);
        wr(TMR_CTRL, 32'h0003_0001);
        for (int i = 0; i < 4; i++) exp_q.push_back(seq[i]);
        step(3);
        rd(TMR_COUNT, got);
        e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL cntwr_before got=%h exp=%h", got, e); end
        wr(TMR_COUNT, 32'h10);
        rd(TMR_COUNT, got);
        e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL cntwr_on_tick got=%h exp=%h", got, e); end
        step(3);
        rd(TMR_COUNT, got);
        e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL cntwr_hold got=%h exp=%h", got, e); end
        step(1);
        rd(TMR_COUNT, got);
        e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL cntwr_resume got=%h exp=%h", got, e); end
        wr(TMR_CTRL, 32'h0);
    endtask

    task automatic test_reset_mid();
        wr(TMR_LOAD, 32'd100);
        wr(TMR_CTRL, 32'h1);
        step(50);
        exp_q.push_back(32'd50);
        rd(TMR_COUNT, got);
        e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL rstmid_count50 got=%h exp=%h", got, e); end
        #3;
        rst_n = 1'b0;
        #2;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0);
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), got);
            e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL rstmid_reg%0d got=%h exp=%h", i, got, e); end
        end
        #3;
        rst_n = 1'b1;
        step(120);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); vectors++;
        if (32'(expired_o) !== e) begin miscompares++; $display("FAIL rstmid_noexpiry got=%b exp=%h", expired_o, e); end
        exp_q.push_back(32'h0);
        rd(TMR_COUNT, got);
        e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL rstmid_count got=%h exp=%h", got, e); end
    endtask

    task automatic test_decode();
        wr(TMR_COUNT, 32'd9);
        bus_if.sel_i   = 1'b0;
        bus_if.addr_i  = TMR_COUNT;
        bus_if.we_i    = 4'hF;
        bus_if.re_i    = 4'hF;
        bus_if.wdata_i = 32'h55;
        #1;
        exp_q.push_back(32'h0);
        got = bus_if.rdata_o;
        e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL decode_rdata got=%h exp=%h", got, e); end
        @(posedge clk);
        #1;
        bus_if.we_i = 4'h0; bus_if.re_i = 4'h0; bus_if.wdata_i = '0;
        exp_q.push_back(32'd9);
        rd(TMR_COUNT, got);
        e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL decode_count got=%h exp=%h", got, e); end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_w1c_race();
        test_count_write_tick();
        test_reset_mid();
        test_decode();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
